// File: rtl/wallace_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined Wallace
// multiplier.
//
// Contents:
//   MIN_WIDTH / MAX_WIDTH / MAX_STAGES : legal parameter envelope
//   pp_row_t / pp_rows_t               : widest partial-product row and row array
//   reduction_layers(rows)             : number of 3:2 layers to reach two rows
//   rows_after(rows, n)                : rows left after n layers
//   layers_in_stage(stage, layers, stages) : even layer-to-stage split
//   boundary_segment(node, layers, segs)   : which segment ends at a layer node
package wallace_pkg;

  localparam int MIN_WIDTH  = 4;
  localparam int MAX_WIDTH  = 32;
  localparam int MAX_STAGES = 4;

  // Widest row that any legal configuration can produce (2*WIDTH bits), and
  // the full partial-product array (WIDTH rows plus the sign-correction row).
  typedef logic [2*MAX_WIDTH-1:0] pp_row_t;
  typedef pp_row_t [MAX_WIDTH:0]  pp_rows_t;

  // Rows remaining after n Wallace layers. Each layer turns every complete
  // group of three rows into two; leftover rows pass straight through.
  function automatic int rows_after(input int rows, input int n);
    int r;
    r = rows;
    for (int i = 0; i < n; i++) begin
      if (r > 2) begin
        r = 2 * (r / 3) + (r % 3);
      end
    end
    return r;
  endfunction

  // Number of layers needed to bring 'rows' down to the final two rows.
  function automatic int reduction_layers(input int rows);
    int r;
    int n;
    r = rows;
    n = 0;
    while (r > 2) begin
      r = 2 * (r / 3) + (r % 3);
      n++;
    end
    return n;
  endfunction

  // Layers assigned to segment 'stage' when 'layers' are spread over 'stages'
  // segments; earlier segments take the remainder so the split differs by at
  // most one layer.
  function automatic int layers_in_stage(input int stage, input int layers,
                                         input int stages);
    return (layers / stages) + ((stage < (layers % stages)) ? 1 : 0);
  endfunction

  // A pipeline register sits at layer node 'node' (node = layers already done)
  // when some segment other than the last ends there. Returns that segment
  // index, or -1 when the node is purely combinational. The last segment ends
  // in the product register, which is handled separately.
  function automatic int boundary_segment(input int node, input int layers,
                                          input int segs);
    int acc;
    acc = 0;
    for (int k = 0; k < segs - 1; k++) begin
      acc += layers_in_stage(k, layers, segs);
      if (acc == node) begin
        return k;
      end
    end
    return -1;
  endfunction

endpackage

// File: rtl/wallace_csa_row.sv
// One 3:2 carry-save row: three addend rows in, a sum row and a carry row out,
// with x + y + z == s + c (mod 2^WIDTH).
//
// Ports:
//   x, y, z : addend rows, WIDTH bits
//   s       : bitwise sum
//   c       : majority carries, already shifted up one column (bit 0 is 0,
//             the carry out of the top column is dropped as it lies beyond
//             the product width)
module wallace_csa_row #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c
);

  logic [WIDTH-2:0] maj;

  assign s   = x ^ y ^ z;
  assign maj = (x[WIDTH-2:0] & y[WIDTH-2:0]) |
               (x[WIDTH-2:0] & z[WIDTH-2:0]) |
               (y[WIDTH-2:0] & z[WIDTH-2:0]);
  assign c   = {maj, 1'b0};

endmodule

// File: rtl/wallace_mult_pl.sv
// Parametrised pipelined Wallace-tree multiplier with valid/ready on both
// sides and a per-operation signed/unsigned mode.
//
// Pipeline: stage 1 registers the partial products (modified Baugh-Wooley
// when signed_mode=1), the 3:2 reduction layers are spread evenly over
// STAGES-1 segments with a register between segments, and the last segment
// ends in the carry-propagate adder feeding p. A single global stall
// (out_valid && !out_ready) freezes every stage.
//
// Parameters: WIDTH (4..32), STAGES (2..4), TAG_WIDTH (tag build only).
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : operand handshake; a, b, signed_mode captured together
//   out_valid/out_ready: result handshake; p is the 2*WIDTH-bit product
//   in_tag/out_tag     : sideband tag travelling with its operands, present
//                        only when WALLACE_MULT_PL_TAG_EN is defined
module wallace_mult_pl
  import wallace_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
`ifdef WALLACE_MULT_PL_TAG_EN
  , parameter int TAG_WIDTH = 4
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
`ifdef WALLACE_MULT_PL_TAG_EN
  , input  logic [TAG_WIDTH-1:0] in_tag
  , output logic [TAG_WIDTH-1:0] out_tag
`endif
);

  localparam int PW     = 2 * WIDTH;
  localparam int ROWS   = WIDTH + 1;                 // pp rows + correction row
  localparam int LAYERS = reduction_layers(ROWS);
  localparam int SEGS   = STAGES - 1;

  logic [STAGES-1:0] vld_reg;
  logic              adv;

  // Every stage advances together unless the consumer is refusing a result.
  assign adv       = !(vld_reg[STAGES-1] && !out_ready);
  assign in_ready  = adv;
  assign out_valid = vld_reg[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg <= '0;
    end else if (adv) begin
      vld_reg <= {vld_reg[STAGES-2:0], in_valid};
    end
  end

  // Partial products. In signed mode, bits where exactly one operand index is
  // the sign position are inverted, and the correction row adds 2^W and
  // 2^(2W-1); together these fold the negative-weight terms into plain adds.
  logic [ROWS-1:0][PW-1:0] pp_next;
  logic [ROWS-1:0][PW-1:0] pp_reg;

  always_comb begin
    pp_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp_next[i][i+j] = (a[j] & b[i]) ^
                          (signed_mode & ((i == WIDTH - 1) != (j == WIDTH - 1)));
      end
    end
    pp_next[WIDTH][WIDTH]  = signed_mode;
    pp_next[WIDTH][PW-1]   = signed_mode;
  end

  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      pp_reg <= pp_next;
    end
  end

  // Reduction layers. Layer gi consumes RI rows and emits RO rows; its input
  // is either the partial-product register, a segment register, or the
  // previous layer's combinational output.
  genvar gi;
  genvar gk;
  for (gi = 0; gi < LAYERS; gi++) begin : g_lay
    localparam int RI  = rows_after(ROWS, gi);
    localparam int RO  = rows_after(ROWS, gi + 1);
    localparam int NG  = RI / 3;
    localparam int SEG = boundary_segment(gi, LAYERS, SEGS);

    logic [RI-1:0][PW-1:0] rin;
    logic [RO-1:0][PW-1:0] rout;

    if (gi == 0) begin : g_src
      assign rin = pp_reg;
    end else if (SEG >= 0) begin : g_src
      logic [RI-1:0][PW-1:0] stage_reg;
      // Loads only when the segment feeding it carries a valid operation.
      always_ff @(posedge clk) begin
        if (adv && vld_reg[SEG]) begin
          stage_reg <= g_lay[gi-1].rout;
        end
      end
      assign rin = stage_reg;
    end else begin : g_src
      assign rin = g_lay[gi-1].rout;
    end

    for (gk = 0; gk < NG; gk++) begin : g_csa
      wallace_csa_row #(
        .WIDTH (PW)
      ) u_csa (
        .x (rin[3*gk]),
        .y (rin[3*gk+1]),
        .z (rin[3*gk+2]),
        .s (rout[2*gk]),
        .c (rout[2*gk+1])
      );
    end

    for (gk = 0; gk < RI - 3 * NG; gk++) begin : g_pass
      assign rout[2*NG+gk] = rin[3*NG+gk];
    end
  end

  // Carry-propagate add of the final two rows; wraps modulo 2^(2W), which is
  // exact for both unsigned and two's-complement products.
  logic [PW-1:0] sum_next;
  logic [PW-1:0] p_reg;

  assign sum_next = g_lay[LAYERS-1].rout[0] + g_lay[LAYERS-1].rout[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      p_reg <= '0;
    end else if (adv && vld_reg[STAGES-2]) begin
      p_reg <= sum_next;
    end
  end

  assign p = p_reg;

`ifdef WALLACE_MULT_PL_TAG_EN
  // Tag shadow pipeline: same enables as the datapath, so a tag always
  // leaves alongside its own product.
  logic [STAGES-1:0][TAG_WIDTH-1:0] tag_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_reg <= '0;
    end else if (adv) begin
      if (in_valid) begin
        tag_reg[0] <= in_tag;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (vld_reg[k-1]) begin
          tag_reg[k] <= tag_reg[k-1];
        end
      end
    end
  end

  assign out_tag = tag_reg[STAGES-1];
`endif

endmodule

// File: tb/tb_wallace_mult_pl.sv
// Directed bench for wallace_mult_pl: an 8-bit/3-stage instance for handshake,
// ordering, stall and reset behaviour, and a 16-bit/4-stage instance for the
// wide signed case (and tag when WALLACE_MULT_PL_TAG_EN is defined).
module tb_wallace_mult_pl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        signed_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;

  logic        in_valid16;
  logic        in_ready16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        sm16;
  logic        out_valid16;
  logic        out_ready16;
  logic [31:0] p16;

`ifdef WALLACE_MULT_PL_TAG_EN
  logic [3:0] in_tag;
  logic [3:0] out_tag;
  logic [3:0] in_tag16;
  logic [3:0] out_tag16;
`endif

  wallace_mult_pl #(
    .WIDTH  (8),
    .STAGES (3)
  ) u_dut8 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .p           (p)
`ifdef WALLACE_MULT_PL_TAG_EN
    , .in_tag    (in_tag)
    , .out_tag   (out_tag)
`endif
  );

  wallace_mult_pl #(
    .WIDTH  (16),
    .STAGES (4)
  ) u_dut16 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid16),
    .in_ready    (in_ready16),
    .a           (a16),
    .b           (b16),
    .signed_mode (sm16),
    .out_valid   (out_valid16),
    .out_ready   (out_ready16),
    .p           (p16)
`ifdef WALLACE_MULT_PL_TAG_EN
    , .in_tag    (in_tag16)
    , .out_tag   (out_tag16)
`endif
  );

  int          checks   = 0;
  int          failures = 0;
  int          out_cnt  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] cur_exp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock of the 8-bit instance. Handshakes are resolved at the falling
  // edge, where the inputs and the registered outputs are settled, then the
  // rising edge performs them.
  task automatic step();
    logic [63:0] e;
    @(negedge clk);
    if (!rst) begin
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          chk("spurious_out", 64'(p), 64'hDEAD_0000);
        end else begin
          e = exp_q.pop_front();
          $display("OUT p=%04h expected=%04h", p, e[15:0]);
          chk("result", 64'(p), e);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib,
                       input logic ism, input logic [63:0] ie);
    in_valid    = 1'b1;
    a           = ia;
    b           = ib;
    signed_mode = ism;
    cur_exp     = ie;
    step();
    in_valid    = 1'b0;
  endtask

  task automatic drain(input int max_steps);
    for (int i = 0; i < max_steps && exp_q.size() > 0; i++) begin
      step();
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  int cnt;
  int base;

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    a           = '0;
    b           = '0;
    signed_mode = 1'b0;
    out_ready   = 1'b1;
    cur_exp     = '0;
    in_valid16  = 1'b0;
    a16         = '0;
    b16         = '0;
    sm16        = 1'b0;
    out_ready16 = 1'b1;
`ifdef WALLACE_MULT_PL_TAG_EN
    in_tag      = '0;
    in_tag16    = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_p", 64'(p), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst16_out_valid", 64'(out_valid16), 64'd0);
    chk("rst16_p", 64'(p16), 64'd0);
`ifdef WALLACE_MULT_PL_TAG_EN
    chk("rst16_out_tag", 64'(out_tag16), 64'd0);
`endif

    // 1: unsigned 255*255, latency 3
    issue(8'd255, 8'd255, 1'b0, 64'hFE01);
    cnt = 1;
    while (!out_valid && cnt < 10) begin
      step();
      cnt++;
    end
    chk("latency3", 64'(cnt), 64'd3);
    chk("p_255x255", 64'(p), 64'hFE01);
    step();

    // 2: signed corners and mixed modes back-to-back
    issue(8'h80, 8'h80, 1'b1, 64'h4000);
    issue(8'hFF, 8'h01, 1'b1, 64'hFFFF);
    issue(8'hFF, 8'h01, 1'b0, 64'h00FF);
    issue(8'h80, 8'hFF, 1'b1, 64'h0080);
    issue(8'h7F, 8'h80, 1'b1, 64'hC080);
    issue(8'h80, 8'hFF, 1'b0, 64'h7F80);
    drain(10);

    // 3: 16-deep stream, one result per cycle
    base = out_cnt;
    for (int i = 0; i < 16; i++) begin
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      issue(8'(i), 8'(i + 1), 1'b0, 64'(i * (i + 1)));
    end
    repeat (3) step();
    chk("stream_count", 64'(out_cnt - base), 64'd16);
    chk("stream_empty", 64'(exp_q.size()), 64'd0);

    // 4: three in flight, consumer stalls for 5 cycles
    out_ready = 1'b0;
    base = out_cnt;
    issue(8'd3, 8'd5, 1'b0, 64'd15);
    issue(8'd10, 8'd12, 1'b0, 64'd120);
    issue(8'h81, 8'h02, 1'b1, 64'hFF02);
    in_valid    = 1'b1;              // must not be taken while stalled
    a           = 8'd9;
    b           = 8'd9;
    signed_mode = 1'b0;
    cur_exp     = 64'd81;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_p", 64'(p), 64'd15);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain(10);
    repeat (2) step();
    chk("stall_count", 64'(out_cnt - base), 64'd3);
    chk("stall_no_dup", 64'(out_valid), 64'd0);

    // 5: reset with two in flight
    issue(8'd2, 8'd3, 1'b0, 64'd6);
    issue(8'd4, 8'd5, 1'b0, 64'd20);
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 8'd1;
    b        = 8'd1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    chk("rst2_p", 64'(p), 64'd0);
    chk("rst2_in_ready", 64'(in_ready), 64'd1);
    base = out_cnt;
    repeat (4) step();
    chk("rst2_no_stale", 64'(out_cnt - base), 64'd0);
    issue(8'd7, 8'd9, 1'b0, 64'd63);
    cnt = 1;
    while (!out_valid && cnt < 10) begin
      step();
      cnt++;
    end
    chk("rst2_latency", 64'(cnt), 64'd3);
    chk("rst2_p_7x9", 64'(p), 64'd63);
    step();

    // 6: 16-bit, 4 stages, signed 0x8000*0x7FFF (tag 0xA when enabled)
    in_valid16 = 1'b1;
    a16        = 16'h8000;
    b16        = 16'h7FFF;
    sm16       = 1'b1;
`ifdef WALLACE_MULT_PL_TAG_EN
    in_tag16   = 4'hA;
`endif
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
`ifdef WALLACE_MULT_PL_TAG_EN
    in_tag16   = 4'h0;
`endif
    cnt = 1;
    while (!out_valid16 && cnt < 12) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    $display("OUT16 p=%08h cycles=%0d", p16, cnt);
    chk("latency4", 64'(cnt), 64'd4);
    chk("p16_signed", 64'(p16), 64'hC000_8000);
`ifdef WALLACE_MULT_PL_TAG_EN
    chk("out_tag16", 64'(out_tag16), 64'hA);
`endif
    // and unsigned max*max on the same instance
    in_valid16 = 1'b1;
    a16        = 16'hFFFF;
    b16        = 16'hFFFF;
    sm16       = 1'b0;
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    cnt = 1;
    while (!out_valid16 && cnt < 12) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    $display("OUT16 p=%08h cycles=%0d", p16, cnt);
    chk("p16_unsigned", 64'(p16), 64'hFFFE_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
